// File: rtl/alu_exec_unit.sv
// Execute-stage ALU with a registered result and valid/ready handshakes on both sides.
// Define ALU_MULDIV_EN to add the iterative 32-step MULT/DIV datapath and the out_hi result.
module alu_exec_unit #(
  parameter int WIDTH = 32,
  parameter int ITERS = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       ALUConf,
  input  logic             Sign,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [WIDTH-1:0] out_hi,
  output logic             out_zero,
  output logic [1:0]       dbg_state
);
  // Handshake: an op transfers on a rising edge with in_valid && in_ready; a result transfers
  // with out_valid && out_ready, and out_valid/out_result/out_hi stay stable until it does.

  if (WIDTH != 32 || ITERS != WIDTH) begin : g_param_chk
    $error("alu_exec_unit supports only WIDTH == ITERS == 32");
  end

  localparam logic [4:0] OP_OR   = 5'b00001;
  localparam logic [4:0] OP_AND  = 5'b00010;
  localparam logic [4:0] OP_SUB  = 5'b00110;
  localparam logic [4:0] OP_SLT  = 5'b00111;
  localparam logic [4:0] OP_NOR  = 5'b01100;
  localparam logic [4:0] OP_XOR  = 5'b01101;
  localparam logic [4:0] OP_SRL  = 5'b10000;
  localparam logic [4:0] OP_SRA  = 5'b11000;
  localparam logic [4:0] OP_SLL  = 5'b11001;

`ifdef ALU_MULDIV_EN
  localparam logic [4:0] OP_MULT = 5'b10100;
  localparam logic [4:0] OP_DIV  = 5'b10101;
  typedef enum logic [1:0] {IDLE = 2'd0, DONE = 2'd1, ITER = 2'd2} state_e;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, DONE = 2'd1} state_e;
`endif

  state_e           state_q, state_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] alu_res;
  logic [4:0]       shamt;
  logic             slt_lt;
  logic             accept;

  assign shamt  = in_a[4:0];
  assign slt_lt = Sign ? ($signed(in_a) < $signed(in_b)) : (in_a < in_b);

  always_comb begin
    case (ALUConf)
      OP_OR:   alu_res = in_a | in_b;
      OP_AND:  alu_res = in_a & in_b;
      OP_SUB:  alu_res = in_a - in_b;
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, slt_lt};
      OP_NOR:  alu_res = ~(in_a | in_b);
      OP_XOR:  alu_res = in_a ^ in_b;
      OP_SRL:  alu_res = in_b >> shamt;
      OP_SRA:  alu_res = $unsigned($signed(in_b) >>> shamt);
      OP_SLL:  alu_res = in_b << shamt;
      default: alu_res = in_a + in_b;
    endcase
  end

`ifdef ALU_MULDIV_EN
  localparam int CW = $clog2(ITERS + 1);
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d, opd_q, opd_d, ohi_q, ohi_d;
  logic               is_div_q, is_div_d, neg_q, neg_d, neg_rem_q, neg_rem_d;
  logic               is_mul, is_div;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     mul_sum, div_sh, div_diff;
  logic [2*WIDTH-1:0] prod, prod_fix;

  assign is_mul   = (ALUConf == OP_MULT);
  assign is_div   = (ALUConf == OP_DIV);
  assign a_mag    = (Sign && in_a[WIDTH-1]) ? -in_a : in_a;
  assign b_mag    = (Sign && in_b[WIDTH-1]) ? -in_b : in_b;
  // MULT: hi accumulates, lo holds the multiplier and collects product low bits as it shifts.
  assign mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opd_q} : '0);
  // DIV: hi is the partial remainder, lo shifts the dividend out and quotient bits in.
  assign div_sh   = {hi_q, lo_q[WIDTH-1]};
  assign div_diff = div_sh - {1'b0, opd_q};
  assign prod     = {hi_q, lo_q};
  assign prod_fix = neg_q ? -prod : prod;
  assign out_hi   = ohi_q;
`else
  assign out_hi   = '0;
`endif

  assign out_valid  = (state_q == DONE);
  assign out_result = res_q;
  assign out_zero   = (res_q == '0);
  assign dbg_state  = state_q;
  assign in_ready   = !flush && ((state_q == IDLE) || ((state_q == DONE) && out_ready));
  assign accept     = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    res_d   = res_q;
`ifdef ALU_MULDIV_EN
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    opd_d     = opd_q;
    ohi_d     = ohi_q;
    is_div_d  = is_div_q;
    neg_d     = neg_q;
    neg_rem_d = neg_rem_q;
`endif
    if (flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (accept) begin
            state_d = DONE;
            res_d   = alu_res;
`ifdef ALU_MULDIV_EN
            ohi_d = '0;
            if (is_div && (in_b == '0)) begin
              res_d = '1;
              ohi_d = in_a;
            end else if (is_mul || is_div) begin
              state_d   = ITER;
              cnt_d     = '0;
              hi_d      = '0;
              lo_d      = is_div ? a_mag : b_mag;
              opd_d     = is_div ? b_mag : a_mag;
              is_div_d  = is_div;
              neg_d     = Sign && (in_a[WIDTH-1] ^ in_b[WIDTH-1]);
              neg_rem_d = Sign && in_a[WIDTH-1];
            end
`endif
          end else if (state_q == DONE && out_ready) begin
            state_d = IDLE;
          end
        end
`ifdef ALU_MULDIV_EN
        ITER: begin
          if (cnt_q == CW'(ITERS)) begin
            state_d = DONE;
            if (is_div_q) begin
              res_d = neg_q ? -lo_q : lo_q;
              ohi_d = neg_rem_q ? -hi_q : hi_q;
            end else begin
              res_d = prod_fix[WIDTH-1:0];
              ohi_d = prod_fix[2*WIDTH-1:WIDTH];
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
            if (is_div_q) begin
              if (!div_diff[WIDTH]) begin
                hi_d = div_diff[WIDTH-1:0];
                lo_d = {lo_q[WIDTH-2:0], 1'b1};
              end else begin
                hi_d = div_sh[WIDTH-1:0];
                lo_d = {lo_q[WIDTH-2:0], 1'b0};
              end
            end else begin
              {hi_d, lo_d} = {mul_sum, lo_q[WIDTH-1:1]};
            end
          end
        end
`endif
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
    end
  end

`ifdef ALU_MULDIV_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      opd_q     <= '0;
      ohi_q     <= '0;
      is_div_q  <= 1'b0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      opd_q     <= opd_d;
      ohi_q     <= ohi_d;
      is_div_q  <= is_div_d;
      neg_q     <= neg_d;
      neg_rem_q <= neg_rem_d;
    end
  end
`endif

endmodule
